// File: rtl/ram_arbiter.sv
// Two-requester (CPU / debug) arbiter for the single-port data RAM with a debug lock mode.
// Define RAM_ARB_STARVE_EN to build the debug starvation override counter.
module ram_arbiter #(
   parameter int unsigned ADDR_W     = 7,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned STARVE_LIM = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   input  logic              dbg_lock,
   output logic              dbg_lock_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_en,
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic {
      SHARED = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t state, state_nxt;
   logic   cpu_pend, dbg_pend;
   logic   starved;

`ifdef RAM_ARB_STARVE_EN
   logic [3:0] starve_cnt;

   assign starved = (starve_cnt == 4'(STARVE_LIM));

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!dbg_req || dbg_gnt) begin
         starve_cnt <= '0;
      end else if (state == SHARED && !starved) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   // No override without the counter; STARVE_LIM is legal only from 1, so this is always 0.
   assign starved = (STARVE_LIM == 0);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= SHARED;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cpu_gnt   = 1'b0;
      dbg_gnt   = 1'b0;
      ram_addr  = '0;
      ram_data  = '0;
      ram_en    = 1'b0;

      case (state)
         SHARED:  if (dbg_lock)  state_nxt = LOCKED;
         LOCKED:  if (!dbg_lock) state_nxt = SHARED;
         default: state_nxt = SHARED;
      endcase

      if (rst) begin
         if (state == LOCKED) begin
            dbg_gnt = dbg_req;
         end else if (dbg_req && (!cpu_req || starved)) begin
            dbg_gnt = 1'b1;
         end else begin
            cpu_gnt = cpu_req;
         end
      end

      if (cpu_gnt) begin
         ram_addr = cpu_addr;
         ram_data = cpu_wdata;
         ram_en   = cpu_we;
      end else if (dbg_gnt) begin
         ram_addr = dbg_addr;
         ram_data = dbg_wdata;
         ram_en   = dbg_we;
      end
   end

   assign dbg_lock_ack = (state == LOCKED);

   // Pending flag marks the cycle the RAM presents ram_q; the return is captured one edge later.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cpu_pend   <= 1'b0;
         dbg_pend   <= 1'b0;
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rdata  <= '0;
      end else begin
         cpu_pend   <= cpu_gnt & ~cpu_we;
         dbg_pend   <= dbg_gnt & ~dbg_we;
         cpu_rvalid <= cpu_pend;
         dbg_rvalid <= dbg_pend;
         if (cpu_pend) cpu_rdata <= ram_q;
         if (dbg_pend) dbg_rdata <= ram_q;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, rule-level reference model and
// read-return scoreboard; honours RAM_ARB_STARVE_EN when defined.
module tb_ram_arbiter;
   localparam int AW  = 7;
   localparam int DW  = 8;
   localparam int LIM = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic          dbg_lock, dbg_lock_ack;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data, ram_q;
   logic          ram_en;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .dbg_lock(dbg_lock), .dbg_lock_ack(dbg_lock_ack),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_en(ram_en), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int          cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural single-port RAM: write on the edge, registered read.
   logic [DW-1:0] ram [128];
   always @(posedge clk) begin
      if (ram_en) ram[ram_addr] <= ram_data;
      ram_q <= ram[ram_addr];
   end

   // Reference model state
   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } rd_t;

   logic [DW-1:0] ref_mem [128];
   rd_t           cpu_q[$];
   rd_t           dbg_q[$];
   bit            m_locked = 1'b0;
   int            m_starve = 0;
   bit            e_cpu = 1'b0, e_dbg = 1'b0;

   initial begin
      for (int i = 0; i < 128; i++) begin
         ram[i]     = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
   end

   always @(posedge clk) cyc++;

   // Predict the winner from the arbitration rules, check the RAM-side outputs, queue read returns.
   always @(negedge clk) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ee;
      e_cpu = 1'b0;
      e_dbg = 1'b0;
      if (rst) begin
         if (m_locked) begin
            e_dbg = dbg_req;
         end else if (cpu_req && dbg_req) begin
`ifdef RAM_ARB_STARVE_EN
            if (m_starve >= LIM) e_dbg = 1'b1;
            else                 e_cpu = 1'b1;
`else
            e_cpu = 1'b1;
`endif
         end else begin
            e_cpu = cpu_req;
            e_dbg = dbg_req;
         end
      end
      ea = e_cpu ? cpu_addr  : (e_dbg ? dbg_addr  : '0);
      ed = e_cpu ? cpu_wdata : (e_dbg ? dbg_wdata : '0);
      ee = e_cpu ? cpu_we    : (e_dbg ? dbg_we    : 1'b0);
      check("cpu_gnt", cpu_gnt, e_cpu);
      check("dbg_gnt", dbg_gnt, e_dbg);
      check("ram_addr", ram_addr, ea);
      check("ram_data", ram_data, ed);
      check("ram_en", ram_en, ee);
      check("dbg_lock_ack", dbg_lock_ack, m_locked);
      if (e_cpu) begin
         if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
         else        cpu_q.push_back('{ref_mem[cpu_addr], cyc + 2});
      end
      if (e_dbg) begin
         if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
         else        dbg_q.push_back('{ref_mem[dbg_addr], cyc + 2});
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         m_locked = 1'b0;
         m_starve = 0;
         cpu_q.delete();
         dbg_q.delete();
      end else begin
         if (!dbg_req || e_dbg)               m_starve = 0;
         else if (!m_locked && m_starve < LIM) m_starve = m_starve + 1;
         m_locked = dbg_lock;
      end
   end

   // Scoreboard monitor: every rvalid must match the oldest queued read, on time.
   always @(negedge clk) begin
      rd_t r;
      if (cpu_rvalid) begin
         if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
         else begin
            r = cpu_q.pop_front();
            check("cpu_rdata", cpu_rdata, r.data);
            check("cpu_rlat", cyc, r.due);
         end
      end else if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
         r = cpu_q.pop_front();
         check("cpu_rvalid_missing", 0, 1);
      end
      if (dbg_rvalid) begin
         if (dbg_q.size() == 0) check("dbg_rvalid_unexpected", 1, 0);
         else begin
            r = dbg_q.pop_front();
            check("dbg_rdata", dbg_rdata, r.data);
            check("dbg_rlat", cyc, r.due);
         end
      end else if (dbg_q.size() != 0 && dbg_q[0].due <= cyc) begin
         r = dbg_q.pop_front();
         check("dbg_rvalid_missing", 0, 1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom % 2 == 0) return AW'($urandom % 8);
      return AW'($urandom);
   endfunction

   initial begin
      rst = 1'b0; dbg_lock = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h01; cpu_wdata = '0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h02; dbg_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_dbg_rvalid", dbg_rvalid, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_dbg_rdata", dbg_rdata, 0);
      check("rst_lock_ack", dbg_lock_ack, 0);
      rst = 1'b1;

      // Both requesting continuously
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) check("first_win_cpu", cpu_gnt, 1);
`ifdef RAM_ARB_STARVE_EN
         check("starve_seq", dbg_gnt, (i % 4 == 3));
`else
         check("starve_seq", dbg_gnt, 0);
`endif
      end
      tick(); cpu_req = 1'b0; dbg_req = 1'b0;

      // CPU write 0x20/0x5A then read back
      tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h20; cpu_wdata = 8'h5A;
      @(negedge clk);
      check("wr_gnt", cpu_gnt, 1);
      check("wr_en", ram_en, 1);
      check("wr_addr", ram_addr, 8'h20);
      check("wr_data", ram_data, 8'h5A);
      tick(); cpu_we = 1'b0;
      tick(); cpu_req = 1'b0;
      tick();
      @(negedge clk);
      check("rd_rvalid", cpu_rvalid, 1);
      check("rd_rdata", cpu_rdata, 8'h5A);

      // Lock entry and exit with the CPU requesting
      tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h05;
      tick(); dbg_lock = 1'b1;
      @(negedge clk);
      check("lock_cpu_n", cpu_gnt, 1);
      check("lock_ack_n", dbg_lock_ack, 0);
      tick(); dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h10;
      @(negedge clk);
      check("lock_cpu_n1", cpu_gnt, 0);
      check("lock_ack_n1", dbg_lock_ack, 1);
      check("lock_dbg_n1", dbg_gnt, 1);
      repeat (3) tick();
      tick(); dbg_lock = 1'b0; dbg_req = 1'b0;
      @(negedge clk);
      check("unlock_cpu_m", cpu_gnt, 0);
      tick();
      @(negedge clk);
      check("unlock_cpu_m1", cpu_gnt, 1);
      check("unlock_ack_m1", dbg_lock_ack, 0);
      tick(); cpu_req = 1'b0;

      // Debug read in flight killed by reset
      tick(); dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h7F;
      @(negedge clk);
      check("inflight_gnt", dbg_gnt, 1);
      tick(); dbg_req = 1'b0; rst = 1'b0;
      tick(); rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("inflight_no_rvalid", dbg_rvalid, 0);
         tick();
      end
      check("inflight_rdata_zero", dbg_rdata, 0);

      // Debug write then read of the top address
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h7F; dbg_wdata = 8'hC3;
      tick(); dbg_we = 1'b0;
      tick(); dbg_req = 1'b0;
      tick();
      @(negedge clk);
      check("wrap_rvalid", dbg_rvalid, 1);
      check("wrap_rdata", dbg_rdata, 8'hC3);

      // Randomized traffic with lock toggles and occasional resets
      for (int n = 0; n < 3000; n++) begin
         tick();
         if (!cpu_req || e_cpu) begin
            cpu_req   = ($urandom % 4) != 0;
            cpu_we    = $urandom % 2;
            cpu_addr  = rand_addr();
            cpu_wdata = DW'($urandom);
         end
         if (!dbg_req || e_dbg) begin
            dbg_req   = ($urandom % 2) != 0;
            dbg_we    = $urandom % 2;
            dbg_addr  = rand_addr();
            dbg_wdata = DW'($urandom);
         end
         if ($urandom % 40 == 0) dbg_lock = ~dbg_lock;
         rst = ($urandom % 300) != 0;
      end

      tick();
      cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0; rst = 1'b1;
      repeat (4) tick();
      check("cpu_queue_drained", cpu_q.size(), 0);
      check("dbg_queue_drained", dbg_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
